// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width and the opcode map used by the
// decoder side (fan-out) and by the result collector (fan-in).
package alu_pkg;

  localparam int OPCODE_W = 5;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 5'd0,
    OP_ADC = 5'd1,
    OP_SUB = 5'd2,
    OP_SBB = 5'd3,
    OP_AND = 5'd4,
    OP_OR  = 5'd5,
    OP_XOR = 5'd6,
    OP_NOT = 5'd7,
    OP_SHL = 5'd8,
    OP_SHR = 5'd9,
    OP_SAR = 5'd10,
    OP_ROL = 5'd11,
    OP_ROR = 5'd12,
    OP_INC = 5'd13,
    OP_DEC = 5'd14,
    OP_NEG = 5'd15
  } opcode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority encoder: first set request at or after ptr (with wrap)
// wins. Purely combinational; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUNITS = 16,
  parameter int PW     = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
  input  logic [NUNITS-1:0] req,
  input  logic [PW-1:0]     ptr,
  input  logic              en,
  output logic [NUNITS-1:0] gnt,
  output logic [PW-1:0]     idx,
  output logic              any
);

  always_comb begin
    int lane;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    lane = 0;
    for (int k = 0; k < NUNITS; k++) begin
      lane = int'(ptr) + k;
      if (lane >= NUNITS) lane = lane - NUNITS;
      if (en && !any && req[lane[PW-1:0]]) begin
        any                = 1'b1;
        gnt[lane[PW-1:0]]  = 1'b1;
        idx                = lane[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_result_collector.sv
// Fan-in of functional-unit results: round-robin arbitration, lane-to-opcode
// encoding, and a small registered FIFO feeding a valid/ready writeback stream.
//
// Handshakes: a lane result transfers when unit_valid[i] && unit_ack[i] at a
// rising edge; the output transfers when out_valid && out_ready at a rising edge.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int NUNITS = 16,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUNITS-1:0]         unit_valid,
  input  logic [NUNITS*WIDTH-1:0]   unit_result,
  output logic [NUNITS-1:0]         unit_ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [OPCODE_W-1:0]       out_opcode,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full
);

  localparam int PW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0]       r_rr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW-1:0]       r_wr_ptr;
  logic [CW-1:0]       r_count;
  logic [WIDTH-1:0]    r_data [DEPTH];
  logic [OPCODE_W-1:0] r_op   [DEPTH];

  logic [PW-1:0]       w_idx;
  logic                w_any;
  logic                w_pop;
  logic                w_can_push;
  logic                w_en;
  logic [WIDTH-1:0]    w_sel_result;
  logic [OPCODE_W-1:0] w_sel_op;

  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_can_push = (r_count < CW'(DEPTH)) || w_pop;
  assign w_en       = w_can_push && !rst;

  rr_arbiter #(
    .NUNITS (NUNITS),
    .PW     (PW)
  ) u_arb (
    .req (unit_valid),
    .ptr (r_rr_ptr),
    .en  (w_en),
    .gnt (unit_ack),
    .idx (w_idx),
    .any (w_any)
  );

  always_comb begin
    w_sel_result = '0;
    for (int i = 0; i < NUNITS; i++) begin
      if (unit_ack[i]) w_sel_result = unit_result[i*WIDTH +: WIDTH];
    end
  end

  assign w_sel_op = OPCODE_W'(w_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= (w_idx == PW'(NUNITS - 1)) ? '0 : w_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_op[i]   <= '0;
      end
    end else begin
      if (w_any) begin
        r_data[r_wr_ptr] <= w_sel_result;
        r_op[r_wr_ptr]   <= w_sel_op;
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_any, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_data   = r_data[r_rd_ptr];
  assign out_opcode = r_op[r_rd_ptr];
  assign count      = r_count;
  assign full       = (r_count == CW'(DEPTH));

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector with an in-order scoreboard on the
// output stream.
module tb_alu_result_collector;

  localparam int N = 16;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [N-1:0]   unit_valid;
  logic [N*W-1:0] unit_result;
  logic [N-1:0]   unit_ack;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [4:0]     out_opcode;
  logic [2:0]     count;
  logic           full;

  int total = 0;
  int bad   = 0;
  int n_push = 0;
  int n_pop  = 0;
  logic [36:0] exp_q[$];

  alu_result_collector #(.NUNITS(N), .WIDTH(W), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .unit_valid  (unit_valid),
    .unit_result (unit_result),
    .unit_ack    (unit_ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_opcode  (out_opcode),
    .count       (count),
    .full        (full)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] v);
    unit_result[i*W +: W] = v;
  endtask

  // One clock: sample handshakes at negedge, feed the scoreboard, then drop
  // acked lanes just after the rising edge.
  task automatic tick();
    logic [N-1:0] a;
    logic         p;
    logic [36:0]  head;
    logic [36:0]  e;
    @(negedge clk);
    a    = unit_ack;
    p    = out_valid && out_ready;
    head = {out_opcode, out_data};
    chk("ack_onehot", {63'd0, $onehot0(a)}, 64'd1);
    chk("ack_subset", {48'd0, a & ~unit_valid}, 64'd0);
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (a[i]) begin
          exp_q.push_back({5'(i), unit_result[i*W +: W]});
          n_push++;
        end
      end
      if (p) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          chk("sb_underflow", {27'd0, head}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_head", {27'd0, head}, {27'd0, e});
        end
      end
    end
    @(posedge clk);
    #1;
    unit_valid = unit_valid & ~a;
  endtask

  logic [15:0] e_ack [5];
  int issued;

  initial begin
    rst         = 1'b1;
    unit_valid  = 16'h0002;
    unit_result = '0;
    out_ready   = 1'b0;
    #2;
    chk("rst_ack", {48'd0, unit_ack}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_opcode", {59'd0, out_opcode}, 64'd0);
    unit_valid = '0;
    tick();
    tick();
    rst = 1'b0;

    // three entries queued, then reset mid-stream
    set_lane(1, 32'h11);
    set_lane(2, 32'h22);
    set_lane(3, 32'h33);
    unit_valid = 16'h000E;
    #1 chk("q_ack1", {48'd0, unit_ack}, 64'h0002);
    tick();
    #1 chk("q_ack2", {48'd0, unit_ack}, 64'h0004);
    tick();
    #1 chk("q_ack3", {48'd0, unit_ack}, 64'h0008);
    tick();
    #1;
    chk("q_count", {61'd0, count}, 64'd3);
    chk("q_valid", {63'd0, out_valid}, 64'd1);
    chk("q_opcode", {59'd0, out_opcode}, 64'd1);
    chk("q_data", {32'd0, out_data}, 64'h11);
    set_lane(4, 32'h44);
    unit_valid[4] = 1'b1;
    #1 chk("q_ack4", {48'd0, unit_ack}, 64'h0010);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", {48'd0, unit_ack}, 64'd0);
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_count", {61'd0, count}, 64'd0);
    chk("mid_rst_full", {63'd0, full}, 64'd0);
    exp_q.delete();
    unit_valid = '0;
    tick();
    tick();
    rst = 1'b0;

    // single-lane latency after reset
    set_lane(5, 32'hDEADBEEF);
    unit_valid = 16'h0020;
    #1 chk("lat_ack", {48'd0, unit_ack}, 64'h0020);
    tick();
    #1;
    chk("lat_valid", {63'd0, out_valid}, 64'd1);
    chk("lat_opcode", {59'd0, out_opcode}, 64'd5);
    chk("lat_data", {32'd0, out_data}, 64'hDEADBEEF);
    chk("lat_count", {61'd0, count}, 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1 chk("lat_drained", {61'd0, count}, 64'd0);

    // round-robin from a fresh reset
    rst = 1'b1;
    #1 exp_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_lane(i, W'(i));
    out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      unit_valid = '1;
      #1 chk("rr_gnt", {48'd0, unit_ack}, 64'd1 << (c % 16));
      tick();
    end
    unit_valid = '0;
    #1 chk("rr_count", {61'd0, count}, 64'd1);
    tick();
    out_ready = 1'b0;
    #1 chk("rr_drained", {61'd0, count}, 64'd0);

    // backpressure to full
    e_ack[0] = 16'h0004;
    e_ack[1] = 16'h0080;
    e_ack[2] = 16'h0200;
    e_ack[3] = 16'h0800;
    e_ack[4] = 16'h0000;
    set_lane(2, 32'h202);
    set_lane(7, 32'h207);
    set_lane(9, 32'h209);
    set_lane(11, 32'h20B);
    set_lane(14, 32'h20E);
    unit_valid = 16'h4A84;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ack", {48'd0, unit_ack}, {48'd0, e_ack[k]});
      tick();
    end
    #1;
    chk("bp_full", {63'd0, full}, 64'd1);
    chk("bp_count", {61'd0, count}, 64'd4);
    chk("bp_lane14_wait", {48'd0, unit_ack}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_ack14", {48'd0, unit_ack}, 64'h4000);
    chk("bp_head2", {59'd0, out_opcode}, 64'd2);
    tick();
    out_ready = 1'b0;
    #1;
    chk("bp_count_same", {61'd0, count}, 64'd4);
    chk("bp_full_same", {63'd0, full}, 64'd1);
    chk("bp_head7", {59'd0, out_opcode}, 64'd7);

    // head stability while stalled
    for (int c = 0; c < 10; c++) begin
      unit_valid = 16'($urandom);
      #1;
      chk("hold_ack", {48'd0, unit_ack}, 64'd0);
      chk("hold_data", {32'd0, out_data}, 64'h207);
      chk("hold_opcode", {59'd0, out_opcode}, 64'd7);
      tick();
    end
    unit_valid = '0;

    // withdrawn request while full
    set_lane(3, 32'h333);
    unit_valid = 16'h0008;
    #1 chk("wd_ack", {48'd0, unit_ack}, 64'd0);
    tick();
    unit_valid = '0;
    #1 chk("wd_count", {61'd0, count}, 64'd4);
    n_pop = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && count != 0; c++) tick();
    out_ready = 1'b0;
    #1;
    chk("wd_pops", 64'(n_pop), 64'd4);
    chk("wd_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("wd_count0", {61'd0, count}, 64'd0);

    // 37-entry stream with random backpressure
    n_push = 0;
    n_pop  = 0;
    issued = 0;
    for (int c = 0; c < 3000 && n_pop < 37; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!unit_valid[i] && issued < 37 && $urandom_range(0, 3) == 0) begin
          set_lane(i, $urandom);
          unit_valid[i] = 1'b1;
          issued++;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("wrap_pushes", 64'(n_push), 64'd37);
    chk("wrap_pops", 64'(n_pop), 64'd37);
    chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("wrap_count", {61'd0, count}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
